// File: rtl/ram_pkg.sv
// ram_pkg: shared types, read-mode constants and lane-count helper for param_dual_port_ram
package ram_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int READ_ASYNC = 0;
  localparam int READ_SYNC = 1;
  function automatic int lanes(int data_w, int byte_w);
    return data_w / byte_w;
  endfunction
endpackage

// File: rtl/ram_parity_gen.sv
// ram_parity_gen: per-lane even-parity generator
// Ports: i_data (NB*BYTE_W) in, o_par (NB) out, one parity bit per byte lane.
module ram_parity_gen #(
  parameter int NB = 1,
  parameter int BYTE_W = 8
) (
  input  logic [NB*BYTE_W-1:0] i_data,
  output logic [NB-1:0]        o_par
);
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign o_par[i] = ^i_data[i*BYTE_W +: BYTE_W];
  end
endmodule

// File: rtl/param_dual_port_ram.sv
// param_dual_port_ram: simple-dual-port RAM with byte enables, clear engine and optional lane parity
// Ports: clk, rst (sync, active-high), clr; write port we/wbe/waddr/wdata/inj_err;
// read port re/raddr -> rdata/rvalid/parity_err; status ready, wr_drop.
// Optional feature: define RAM_PARITY_EN to store and check one even-parity bit per lane.
module param_dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 3,
  parameter int DEPTH = 8,
  parameter int READ_MODE = READ_ASYNC
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clr,
  input  logic                               we,
  input  logic [lanes(DATA_W, BYTE_W)-1:0]   wbe,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W-1:0]                  wdata,
  input  logic                               re,
  input  logic [ADDR_W-1:0]                  raddr,
  output logic [DATA_W-1:0]                  rdata,
  output logic                               rvalid,
  output logic                               ready,
  output logic                               wr_drop,
  input  logic                               inj_err,
  output logic [lanes(DATA_W, BYTE_W)-1:0]   parity_err
);
  localparam int NB = lanes(DATA_W, BYTE_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic r_wr_drop;
  logic w_ready, w_wr_ok, w_rd_in, w_rd_ok;
  logic [DATA_W-1:0] w_rd;
  logic [NB-1:0] w_perr;
  assign w_ready = r_state == ST_READY;
  // a write sampled together with clr loses to the clear
  assign w_wr_ok = w_ready & we & ~clr & ~rst & ({1'b0, waddr} < DEPTH_L);
  assign w_rd_in = {1'b0, raddr} < DEPTH_L;
  assign w_rd = w_rd_in ? r_mem[raddr] : '0;
  assign w_rd_ok = re & w_ready;
  assign ready = w_ready;
  assign wr_drop = r_wr_drop;
  always_comb begin
    w_next = clr ? ST_CLEAR : (r_state == ST_CLEAR && r_cnt == LAST) ? ST_READY : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt <= '0;
      r_wr_drop <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt <= (clr || r_state == ST_READY || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
      r_wr_drop <= we & (~w_ready | clr);
    end
  end
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)
      r_mem[r_cnt] <= '0;
    else if (w_wr_ok)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) r_mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
  end
`ifdef RAM_PARITY_EN
  logic [NB-1:0] r_par [DEPTH];
  logic [NB-1:0] w_wpar, w_rpar;
  ram_parity_gen #(.NB(NB), .BYTE_W(BYTE_W)) u_wpar (.i_data(wdata), .o_par(w_wpar));
  ram_parity_gen #(.NB(NB), .BYTE_W(BYTE_W)) u_rpar (.i_data(w_rd), .o_par(w_rpar));
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR)
      r_par[r_cnt] <= '0;
    else if (w_wr_ok)
      for (int i = 0; i < NB; i++)
        if (wbe[i]) r_par[waddr][i] <= w_wpar[i] ^ inj_err;
  end
  assign w_perr = w_rd_in ? (r_par[raddr] ^ w_rpar) : '0;
`else
  logic w_unused;
  assign w_unused = inj_err;
  assign w_perr = '0;
`endif
  if (READ_MODE == READ_SYNC) begin : g_sync
    logic [DATA_W-1:0] r_rdata;
    logic r_rvalid;
    logic [NB-1:0] r_perr;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rdata <= '0;
        r_rvalid <= 1'b0;
        r_perr <= '0;
      end else begin
        r_rvalid <= w_rd_ok;
        r_perr <= w_rd_ok ? w_perr : '0;
        if (w_rd_ok) r_rdata <= w_rd;
      end
    end
    assign rdata = r_rdata;
    assign rvalid = r_rvalid;
    assign parity_err = r_perr;
  end else begin : g_async
    assign rdata = w_ready ? w_rd : '0;
    assign rvalid = w_rd_ok;
    assign parity_err = w_rd_ok ? w_perr : '0;
  end
endmodule

// File: tb/tb_param_dual_port_ram.sv
// tb_param_dual_port_ram: directed bench for a 32-bit registered-read RAM and an 8-bit async-read RAM
module tb_param_dual_port_ram;
  logic clk = 1'b0;
  logic rst, clr, we, re, inj_err;
  logic [3:0] wbe;
  logic [2:0] waddr, raddr;
  logic [31:0] wdata;
  logic [31:0] s_rdata;
  logic s_rvalid, s_ready, s_wr_drop;
  logic [3:0] s_perr;
  logic [7:0] a_rdata;
  logic a_rvalid, a_ready, a_wr_drop;
  logic [0:0] a_perr;
  int n_chk = 0;
  int n_err = 0;
`ifdef RAM_PARITY_EN
  localparam logic [3:0] PE = 4'hf;
`else
  localparam logic [3:0] PE = 4'h0;
`endif
  always #5 clk = ~clk;
  param_dual_port_ram #(.DATA_W(32), .BYTE_W(8), .ADDR_W(3), .DEPTH(8), .READ_MODE(1)) u_s (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(s_rdata), .rvalid(s_rvalid), .ready(s_ready),
    .wr_drop(s_wr_drop), .inj_err(inj_err), .parity_err(s_perr)
  );
  param_dual_port_ram #(.DATA_W(8), .BYTE_W(8), .ADDR_W(3), .DEPTH(8), .READ_MODE(0)) u_a (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wbe(wbe[0:0]), .waddr(waddr), .wdata(wdata[7:0]),
    .re(re), .raddr(raddr), .rdata(a_rdata), .rvalid(a_rvalid), .ready(a_ready),
    .wr_drop(a_wr_drop), .inj_err(inj_err), .parity_err(a_perr)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1; clr = 0; we = 0; re = 0; inj_err = 0; wbe = 4'hf; waddr = 0; raddr = 0; wdata = 0;
    tick(); tick();
    chk("rst_ready", s_ready, 0);
    chk("rst_rvalid", s_rvalid, 0);
    chk("rst_rdata", s_rdata, 0);
    chk("rst_wr_drop", s_wr_drop, 0);
    chk("rst_perr", s_perr, 0);
    chk("rst_a_ready", a_ready, 0);
    rst = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("init_ready", s_ready, (i == 8) ? 1 : 0);
    end
    chk("init_a_ready", a_ready, 1);
    re = 1;
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i);
      #1;
      chk("init_a_rdata", a_rdata, 0);
      chk("init_a_rvalid", a_rvalid, 1);
      tick();
      chk("init_s_rdata", s_rdata, 0);
      chk("init_s_rvalid", s_rvalid, 1);
    end
    re = 0;
    tick();
    chk("s_rvalid_idle", s_rvalid, 0);
    chk("a_rvalid_idle", a_rvalid, 0);
    we = 1; waddr = 3; wbe = 4'hf; wdata = 32'hAABBCCDD;
    tick();
    wbe = 4'b0101; wdata = 32'h11223344;
    tick();
    we = 0; re = 1; raddr = 3;
    #1;
    chk("be_a_rdata", a_rdata, 32'h44);
    tick();
    chk("be_s_rdata", s_rdata, 32'hAA22CC44);
    re = 1; raddr = 5; we = 1; waddr = 5; wbe = 4'hf; wdata = 32'h5A;
    #1;
    chk("rw_a_old", a_rdata, 0);
    tick();
    chk("rw_s_old", s_rdata, 0);
    chk("rw_s_rvalid", s_rvalid, 1);
    chk("rw_a_new", a_rdata, 32'h5A);
    we = 0;
    tick();
    chk("rw_s_new", s_rdata, 32'h5A);
    we = 1; wbe = 4'h0; wdata = 32'hFFFFFFFF;
    tick();
    we = 0;
    tick();
    chk("wbe0_s", s_rdata, 32'h5A);
    chk("wbe0_a", a_rdata, 32'h5A);
    re = 0; we = 1; wbe = 4'hf; wdata = 32'hFFFFFFFF;
    for (int i = 0; i < 8; i++) begin
      waddr = 3'(i);
      tick();
    end
    raddr = 6; re = 1;
    #1;
    chk("fill_a", a_rdata, 32'hFF);
    clr = 1; we = 1; waddr = 2; wdata = 32'h12;
    tick();
    chk("clr_drop1", s_wr_drop, 1);
    chk("clr_ready", s_ready, 0);
    chk("clr_a_rvalid", a_rvalid, 0);
    clr = 0;
    tick();
    chk("clr_drop2", s_wr_drop, 1);
    chk("clr_a_drop", a_wr_drop, 1);
    we = 0;
    tick();
    chk("clr_drop_end", s_wr_drop, 0);
    for (int n = 4; n <= 9; n++) begin
      tick();
      if (n >= 8) chk("clr_ready_rise", s_ready, (n == 9) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) begin
      raddr = 3'(i);
      #1;
      chk("clr_a_rdata", a_rdata, 0);
      tick();
      chk("clr_s_rdata", s_rdata, 0);
    end
    re = 0; clr = 1;
    tick();
    clr = 0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1; re = 1;
    tick();
    chk("rmc_ready", s_ready, 0);
    chk("rmc_rvalid", s_rvalid, 0);
    rst = 0; re = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i >= 7) chk("rmc_ready_rise", s_ready, (i == 8) ? 1 : 0);
    end
    we = 1; waddr = 1; wbe = 4'hf; wdata = 32'h0F; inj_err = 1;
    tick();
    we = 0; inj_err = 0; re = 1; raddr = 1;
    #1;
    chk("par_a_rdata", a_rdata, 32'h0F);
    chk("par_a_err", a_perr, PE[0]);
    tick();
    chk("par_s_rdata", s_rdata, 32'h0F);
    chk("par_s_err", s_perr, PE);
    re = 0;
    tick();
    chk("par_s_idle", s_perr, 0);
    chk("par_a_idle", a_perr, 0);
    we = 1;
    tick();
    we = 0; re = 1;
    #1;
    chk("par_a_clean", a_perr, 0);
    tick();
    chk("par_s_clean", s_perr, 0);
    chk("par_s_rvalid", s_rvalid, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
